// File: rtl/redirect_ctrl.sv
// redirect_ctrl
//   Sequences front-end redirects. Picks the oldest pending redirect request
//   (wb > priv > ex1 > id), holds its target until IF0 accepts it, drains the
//   caches first for barrier-type privileged refetches, and keeps fetch stalled
//   for FLUSH_HOLD cycles after every accepted redirect.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   wb_req/wb_pc                WB redirect (exception/ertn)
//   priv_req/priv_barrier/priv_pc  privileged refetch, barrier => drain caches
//   ex1_req/ex1_pc              EX1 branch mispredict
//   id_req/id_pc                ID predecode jump
//   icache_idle, dcache_idle    caches have nothing outstanding
//   if0_ready                   IF0 takes the redirect this cycle
//   redir_valid/redir_pc/redir_src  redirect offered to IF0 (src 3=wb 2=priv 1=ex1 0=id)
//   latch_pulse                 one cycle high when a request is latched
//   fetch_stall                 fetch must not issue
//   redir_cnt                   saturating count of accepted redirects
module redirect_ctrl #(
    parameter int PC_W       = 32,
    parameter int FLUSH_HOLD = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_req,
    input  logic [PC_W-1:0]  wb_pc,
    input  logic             priv_req,
    input  logic             priv_barrier,
    input  logic [PC_W-1:0]  priv_pc,
    input  logic             ex1_req,
    input  logic [PC_W-1:0]  ex1_pc,
    input  logic             id_req,
    input  logic [PC_W-1:0]  id_pc,
    input  logic             icache_idle,
    input  logic             dcache_idle,
    input  logic             if0_ready,
    output logic             redir_valid,
    output logic [PC_W-1:0]  redir_pc,
    output logic [1:0]       redir_src,
    output logic             latch_pulse,
    output logic             fetch_stall,
    output logic [CNT_W-1:0] redir_cnt
);

    localparam int HW = (FLUSH_HOLD > 0) ? $clog2(FLUSH_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        ISSUE,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [PC_W-1:0] pc_d;
    logic [1:0]      src_d;
    logic            latch_d;
    logic [CNT_W-1:0] cnt_d;

    // Fixed-priority selection of the oldest request
    logic            win_any;
    logic [1:0]      win_src;
    logic [PC_W-1:0] win_pc;
    logic            win_bar;
    logic            win_higher;

    always_comb begin
        win_any = wb_req | priv_req | ex1_req | id_req;
        win_src = '0;
        win_pc  = '0;
        win_bar = 1'b0;
        if (wb_req) begin
            win_src = 2'd3;
            win_pc  = wb_pc;
        end else if (priv_req) begin
            win_src = 2'd2;
            win_pc  = priv_pc;
            win_bar = priv_barrier;
        end else if (ex1_req) begin
            win_src = 2'd1;
            win_pc  = ex1_pc;
        end else if (id_req) begin
            win_src = 2'd0;
            win_pc  = id_pc;
        end
        // Only a strictly older request may displace the latched one
        win_higher = win_any && (win_src > redir_src);
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pc_d    = redir_pc;
        src_d   = redir_src;
        latch_d = 1'b0;
        cnt_d   = redir_cnt;

        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    latch_d = 1'b1;
                end
            end
            DRAIN: begin
                if (wb_req) begin
                    latch_d = 1'b1;
                end else if (icache_idle && dcache_idle) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (redir_valid && if0_ready) begin
                    if (redir_cnt != '1) begin
                        cnt_d = redir_cnt + CNT_W'(1);
                    end
                    if (FLUSH_HOLD == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        hold_d  = HW'(FLUSH_HOLD);
                    end
                end
                // An older request arriving with the handshake replaces the
                // hold window entirely; the latch below overrides state_d.
                if (win_higher) begin
                    latch_d = 1'b1;
                end
            end
            HOLD: begin
                if (win_any) begin
                    latch_d = 1'b1;
                end else if (hold_q <= HW'(1)) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (latch_d) begin
            pc_d    = win_pc;
            src_d   = win_src;
            hold_d  = '0;
            state_d = win_bar ? DRAIN : ISSUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            redir_src   <= '0;
            latch_pulse <= 1'b0;
            fetch_stall <= 1'b0;
            redir_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            redir_valid <= (state_d == ISSUE);
            redir_pc    <= pc_d;
            redir_src   <= src_d;
            latch_pulse <= latch_d;
            fetch_stall <= (state_d != IDLE);
            redir_cnt   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_redirect_ctrl.sv
module tb_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_req, priv_req, priv_barrier, ex1_req, id_req;
    logic [31:0] wb_pc, priv_pc, ex1_pc, id_pc;
    logic        icache_idle, dcache_idle, if0_ready;

    logic        redir_valid, latch_pulse, fetch_stall;
    logic [31:0] redir_pc, redir_cnt;
    logic [1:0]  redir_src;

    logic        s_valid, s_latch, s_stall;
    logic [31:0] s_pc;
    logic [1:0]  s_src, s_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    redirect_ctrl #(.PC_W(32), .FLUSH_HOLD(2), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .wb_req(wb_req), .wb_pc(wb_pc),
        .priv_req(priv_req), .priv_barrier(priv_barrier), .priv_pc(priv_pc),
        .ex1_req(ex1_req), .ex1_pc(ex1_pc),
        .id_req(id_req), .id_pc(id_pc),
        .icache_idle(icache_idle), .dcache_idle(dcache_idle),
        .if0_ready(if0_ready),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_src(redir_src),
        .latch_pulse(latch_pulse), .fetch_stall(fetch_stall), .redir_cnt(redir_cnt)
    );

    // Narrow counter copy driven by the same stimulus, used for saturation
    redirect_ctrl #(.PC_W(32), .FLUSH_HOLD(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .wb_req(wb_req), .wb_pc(wb_pc),
        .priv_req(priv_req), .priv_barrier(priv_barrier), .priv_pc(priv_pc),
        .ex1_req(ex1_req), .ex1_pc(ex1_pc),
        .id_req(id_req), .id_pc(id_pc),
        .icache_idle(icache_idle), .dcache_idle(dcache_idle),
        .if0_ready(if0_ready),
        .redir_valid(s_valid), .redir_pc(s_pc), .redir_src(s_src),
        .latch_pulse(s_latch), .fetch_stall(s_stall), .redir_cnt(s_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        wb_req = 1'b0; priv_req = 1'b0; priv_barrier = 1'b0;
        ex1_req = 1'b0; id_req = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [1:0] src, input logic lp, input logic st);
        check({tag, ".valid"}, 64'(redir_valid), 64'(v));
        check({tag, ".pc"},    64'(redir_pc),    64'(pc));
        check({tag, ".src"},   64'(redir_src),   64'(src));
        check({tag, ".latch"}, 64'(latch_pulse), 64'(lp));
        check({tag, ".stall"}, 64'(fetch_stall), 64'(st));
    endtask

    initial begin
        clear_reqs();
        wb_pc = '0; priv_pc = '0; ex1_pc = '0; id_pc = '0;
        icache_idle = 1'b1; dcache_idle = 1'b1; if0_ready = 1'b0;
        #1;
        chk_out("rst0", 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        check("rst0.cnt", 64'(redir_cnt), 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: ex1 redirect accepted immediately, then 2-cycle hold
        ex1_req = 1'b1; ex1_pc = 32'h1c000040; if0_ready = 1'b1;
        tick();
        chk_out("ex1.latch", 1'b1, 32'h1c000040, 2'd1, 1'b1, 1'b1);
        clear_reqs();
        tick();
        chk_out("ex1.hold1", 1'b0, 32'h1c000040, 2'd1, 1'b0, 1'b1);
        check("ex1.cnt", 64'(redir_cnt), 64'd1);
        tick();
        check("ex1.hold2.stall", 64'(fetch_stall), 64'd1);
        tick();
        chk_out("ex1.idle", 1'b0, 32'h1c000040, 2'd1, 1'b0, 1'b0);
        if0_ready = 1'b0;

        // 2: id and wb together, wb wins
        id_req = 1'b1; id_pc = 32'h100; wb_req = 1'b1; wb_pc = 32'h1c008000;
        tick();
        chk_out("pri.latch", 1'b1, 32'h1c008000, 2'd3, 1'b1, 1'b1);
        clear_reqs();
        tick();
        chk_out("pri.wait", 1'b1, 32'h1c008000, 2'd3, 1'b0, 1'b1);
        if0_ready = 1'b1;
        tick();
        check("pri.cnt", 64'(redir_cnt), 64'd2);
        if0_ready = 1'b0;
        tick(); tick();
        check("pri.idle.stall", 64'(fetch_stall), 64'd0);
        check("pri.idle.valid", 64'(redir_valid), 64'd0);

        // 3: ex1 stalled by IF0, younger id ignored, older wb preempts
        ex1_req = 1'b1; ex1_pc = 32'h1c000080;
        tick();
        chk_out("pre.latch", 1'b1, 32'h1c000080, 2'd1, 1'b1, 1'b1);
        clear_reqs();
        id_req = 1'b1; id_pc = 32'h444;
        tick();
        chk_out("pre.id_ign", 1'b1, 32'h1c000080, 2'd1, 1'b0, 1'b1);
        clear_reqs();
        tick(); tick();
        wb_req = 1'b1; wb_pc = 32'h200;
        tick();
        chk_out("pre.wb", 1'b1, 32'h200, 2'd3, 1'b1, 1'b1);
        clear_reqs();
        if0_ready = 1'b1;
        tick();
        check("pre.cnt", 64'(redir_cnt), 64'd3);
        check("pre.acc.valid", 64'(redir_valid), 64'd0);
        if0_ready = 1'b0;
        tick(); tick();

        // 4a: barrier priv waits for dcache to drain; ex1 during drain ignored
        dcache_idle = 1'b0;
        priv_req = 1'b1; priv_barrier = 1'b1; priv_pc = 32'h1c001000;
        tick();
        chk_out("drn.latch", 1'b0, 32'h1c001000, 2'd2, 1'b1, 1'b1);
        clear_reqs();
        ex1_req = 1'b1; ex1_pc = 32'h999;
        tick();
        chk_out("drn.ex1_ign", 1'b0, 32'h1c001000, 2'd2, 1'b0, 1'b1);
        clear_reqs();
        tick(); tick(); tick();
        check("drn.wait.valid", 64'(redir_valid), 64'd0);
        dcache_idle = 1'b1;
        tick();
        chk_out("drn.issue", 1'b1, 32'h1c001000, 2'd2, 1'b0, 1'b1);
        if0_ready = 1'b1;
        tick();
        check("drn.cnt", 64'(redir_cnt), 64'd4);
        if0_ready = 1'b0;
        tick(); tick();
        check("drn.idle.stall", 64'(fetch_stall), 64'd0);

        // 4b: wb preempts a drain without waiting for the caches
        icache_idle = 1'b0;
        priv_req = 1'b1; priv_barrier = 1'b1; priv_pc = 32'h1c002000;
        tick();
        check("drwb.drain.valid", 64'(redir_valid), 64'd0);
        clear_reqs();
        tick();
        wb_req = 1'b1; wb_pc = 32'h1c00f000;
        tick();
        chk_out("drwb.wb", 1'b1, 32'h1c00f000, 2'd3, 1'b1, 1'b1);
        clear_reqs();
        if0_ready = 1'b1;
        tick();
        check("drwb.cnt", 64'(redir_cnt), 64'd5);
        if0_ready = 1'b0;
        icache_idle = 1'b1;
        tick(); tick();

        // 5: handshake coincides with older wb -> counted, no hold gap
        ex1_req = 1'b1; ex1_pc = 32'h1c000100;
        tick();
        check("hs.issue.valid", 64'(redir_valid), 64'd1);
        clear_reqs();
        if0_ready = 1'b1; wb_req = 1'b1; wb_pc = 32'h300;
        tick();
        chk_out("hs.wb", 1'b1, 32'h300, 2'd3, 1'b1, 1'b1);
        check("hs.cnt", 64'(redir_cnt), 64'd6);
        clear_reqs();
        tick();
        check("hs.cnt2", 64'(redir_cnt), 64'd7);
        check("hs.acc.valid", 64'(redir_valid), 64'd0);
        if0_ready = 1'b0;
        tick(); tick();
        check("sat.cnt", 64'(s_cnt), 64'd3);

        // 6: asynchronous reset mid-ISSUE
        ex1_req = 1'b1; ex1_pc = 32'h1c000200;
        tick();
        check("arst.pre.valid", 64'(redir_valid), 64'd1);
        clear_reqs();
        #2 rst = 1'b1;
        #1;
        chk_out("arst", 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        check("arst.cnt", 64'(redir_cnt), 64'd0);
        check("arst.sat.cnt", 64'(s_cnt), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk_out("arst.after", 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/redirect_ctrl.md
Name: redirect_ctrl

Overview:
- Sequences front-end redirects for the pipeline, alongside the combinational flush-priority logic.
- Collects redirect requests from WB (exception/ertn), privileged refetch (CSR/TLB/ibar), EX1 (branch mispredict) and ID (predecode jump), and selects the oldest.
- Holds the winning target until IF0 accepts it. Barrier-type privileged redirects first wait for both caches to drain.
- Keeps fetch stalled for a programmable settle window after each redirect.

Parameters:
- PC_W, 32, width of all PC buses.
- FLUSH_HOLD, 2, cycles fetch stays stalled after IF0 accepts a redirect (0 = no hold).
- CNT_W, 32, width of the redirect performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wb_req  in  1  WB redirect request
- wb_pc  in  PC_W  WB target
- priv_req  in  1  privileged refetch request
- priv_barrier  in  1  qualifies priv_req: drain caches before issuing
- priv_pc  in  PC_W  privileged target
- ex1_req  in  1  EX1 mispredict request
- ex1_pc  in  PC_W  EX1 target
- id_req  in  1  ID predecode redirect request
- id_pc  in  PC_W  ID target
- icache_idle  in  1  icache has no outstanding miss/refill
- dcache_idle  in  1  dcache has no outstanding miss/writeback
- if0_ready  in  1  IF0 can take a redirect this cycle
- redir_valid  out  1  redirect offered to IF0
- redir_pc  out  PC_W  redirect target
- redir_src  out  2  source of latched redirect: 3=wb, 2=priv, 1=ex1, 0=id
- latch_pulse  out  1  one-cycle pulse when a new request is latched
- fetch_stall  out  1  fetch must not issue
- redir_cnt  out  CNT_W  accepted redirects, saturating

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; hold counter 0; redir_cnt 0.
- All outputs are registered. A request sampled at edge N is visible at edge N+1.
- Priority: wb > priv > ex1 > id. Only the winner is latched (pc, src, barrier flag).
- "Preempt" means: latch a strictly higher-priority request, pulse latch_pulse, then re-enter DRAIN or ISSUE by the winner's type.
- IDLE:
  - On any request, latch the winner and pulse latch_pulse.
  - Go to DRAIN if the winner is priv with priv_barrier=1, else go to ISSUE.
- DRAIN: redir_valid=0, fetch_stall=1.
  - When icache_idle & dcache_idle are both high in the same cycle, go to ISSUE.
  - wb_req preempts immediately; WB never drains.
  - All other requests are ignored.
- ISSUE: redir_valid=1 with redir_pc and redir_src stable until accepted.
  - On redir_valid & if0_ready: redir_cnt increments (saturates at all-ones). Go to HOLD with counter = FLUSH_HOLD, or to IDLE if FLUSH_HOLD=0.
  - A strictly higher-priority request while not accepted preempts; redir_valid stays 1 with the new pc the next cycle.
  - Equal- or lower-priority requests are ignored.
  - Higher-priority request in the same cycle as the handshake: the handshake completes and counts. The new request is latched and goes straight to ISSUE/DRAIN; HOLD is skipped.
- HOLD: redir_valid=0, fetch_stall=1.
  - Counter decrements each cycle; at 1, go to IDLE.
  - Any request (any priority) preempts: latch it and go to ISSUE/DRAIN.
- fetch_stall = (state != IDLE), registered. IDLE and latch happen on the same edge, so stall asserts the cycle after the request.
- Simultaneous requests: only the winner is latched; losers must re-request and are not queued.
- Reset mid-redirect discards the pending redirect; no handshake is counted.
- redir_pc/redir_src hold their last value in IDLE; latch_pulse is 0 except on latch cycles.

Test Plan:
- Reset, then ex1_req=1 with ex1_pc=0x1c000040 and if0_ready=1 -> next cycle redir_valid=1, pc=0x1c000040, src=1, latch_pulse=1; following cycle HOLD for 2 cycles with fetch_stall=1; then IDLE; redir_cnt=1.
- id_req and wb_req in the same cycle (id_pc=0x100, wb_pc=0x1c008000) -> latched pc=0x1c008000, src=3; id request dropped.
- ex1 redirect with if0_ready=0 for 3 cycles, then wb_req with wb_pc=0x200 -> redir_pc switches to 0x200 and src=3 while redir_valid stays 1; id_req during the wait is ignored.
- priv_req with priv_barrier=1, dcache_idle=0 for 5 cycles -> redir_valid stays 0; once both caches are idle, ISSUE the next cycle; a wb_req during the drain preempts without waiting.
- Handshake cycle coincides with wb_req=0x300 -> redir_cnt increments; next cycle redir_valid=1 with pc=0x300 and no HOLD gap; preset redir_cnt to all-ones and confirm it stays all-ones.
- rst asserted asynchronously mid-ISSUE -> all outputs go to 0 immediately, without waiting for a clock edge.
